// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// PS/2 host-to-device command transmitter sharing the open-collector PS2_CLK/PS2_DAT lines.
// Optional macro PS2_TX_RETRY_EN: resend the latched byte up to MAX_RETRY times on NACK/timeout.
module ps2_host_tx #(
  parameter int CLK_FREQ    = 50000000,
  parameter int INHIBIT_US  = 120,
  parameter int TIMEOUT_US  = 15000,
  parameter int SYNC_STAGES = 2
`ifdef PS2_TX_RETRY_EN
  , parameter int MAX_RETRY = 2
`endif
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       active
);
  localparam int          INHIBIT_CYC = CLK_FREQ / 1000000 * INHIBIT_US;
  localparam int          TIMEOUT_CYC = CLK_FREQ / 1000000 * TIMEOUT_US;
  localparam logic [19:0] INH_LAST    = 20'(INHIBIT_CYC - 1);
  localparam logic [19:0] TO_LAST     = 20'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_INHIBIT = 2'd1;
  localparam logic [1:0] S_XFER    = 2'd2;  // RTS plus the 11 device clocks
  localparam logic [1:0] S_ACK     = 2'd3;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s, w_dat_s, w_fe;

  logic [1:0]  r_state;
  logic [19:0] r_timer;
  logic [3:0]  r_bitn;
  logic [7:0]  r_data;
  logic        r_parity;
  logic [9:0]  r_shift;
  logic        r_done, r_error, r_clk_oe, r_dat_oe;
  logic [3:0]  w_bitn_nx;
  logic        w_timeout, w_nack, w_fail, w_retry;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fe    = r_clk_prev & ~w_clk_s;

  // Synchronisers idle high so a released bus never looks like an edge after reset.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_dat_in};
      r_clk_prev <= w_clk_s;
    end
  end

  assign w_bitn_nx = r_bitn + 4'd1;
  // The done cycle itself is exempt so a late timeout can never overlap done.
  assign w_timeout = ((r_state == S_XFER) || (r_state == S_ACK)) && !r_done &&
                     (r_timer == TO_LAST);
  assign w_nack    = (r_state == S_XFER) && w_fe && (w_bitn_nx == 4'd11) && w_dat_s;
  assign w_fail    = w_timeout || w_nack;

`ifdef PS2_TX_RETRY_EN
  localparam int           RW        = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  logic [RW-1:0] r_retry;

  assign w_retry = (r_retry < RETRY_MAX);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)                  r_retry <= '0;
    else if (cmd_valid && cmd_ready) r_retry <= '0;
    else if (w_fail && w_retry)    r_retry <= r_retry + 1'b1;
  end
`else
  assign w_retry = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_bitn   <= '0;
      r_data   <= '0;
      r_parity <= 1'b0;
      r_shift  <= '1;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_timer <= r_timer + 20'd1;
      if (w_fail) begin
        // A retry restarts straight from inhibit with the byte still latched.
        r_state  <= w_retry ? S_INHIBIT : S_IDLE;
        r_error  <= ~w_retry;
        r_clk_oe <= w_retry;
        r_dat_oe <= 1'b0;
        r_timer  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cmd_valid) begin
              r_data   <= cmd_data;
              r_parity <= ~^cmd_data;
              r_state  <= S_INHIBIT;
              r_timer  <= '0;
              r_clk_oe <= 1'b1;
              r_dat_oe <= 1'b0;
            end
          end
          S_INHIBIT: begin
            if (r_timer == INH_LAST) begin
              r_state  <= S_XFER;
              r_timer  <= '0;
              r_bitn   <= '0;
              r_shift  <= {1'b1, r_parity, r_data};
              r_clk_oe <= 1'b0;
              r_dat_oe <= 1'b1;
            end
          end
          S_XFER: begin
            if (w_fe) begin
              r_bitn <= w_bitn_nx;
              if (w_bitn_nx == 4'd11) begin
                r_state <= S_ACK;
              end else begin
                // Data, parity, then the trailing 1 releases the line for stop.
                r_dat_oe <= ~r_shift[0];
                r_shift  <= {1'b1, r_shift[9:1]};
              end
            end
          end
          default: begin
            if (r_done)                  r_state <= S_IDLE;
            else if (w_clk_s && w_dat_s) r_done  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = ~cmd_ready;
  assign active     = busy;
  assign done       = r_done;
  assign error      = r_error;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx: behavioural PS/2 device on wired-AND lines, frame model from byte arithmetic.
module tb_ps2_host_tx;
  localparam int INH_CYC = 120;
  localparam int TO_CYC  = 2000;
  localparam int H       = 10;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b1;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe, active;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  wire        ps2_clk_line = (ps2_clk_oe || !dev_clk) ? 1'b0 : 1'b1;
  wire        ps2_dat_line = (ps2_dat_oe || !dev_dat) ? 1'b0 : 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_host_tx #(.CLK_FREQ(1000000), .INHIBIT_US(120), .TIMEOUT_US(2000), .SYNC_STAGES(2)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .busy(busy), .done(done), .error(error),
    .ps2_clk_in(ps2_clk_line), .ps2_dat_in(ps2_dat_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .active(active));

  // Passive monitor: pulse/phase counters and timestamps, sampled on the falling edge.
  int   cyc = 0, done_hi = 0, err_hi = 0, inh_phases = 0, inh_run = 0, last_inh_len = 0;
  int   rts_cyc = 0, err_cyc = 0, overlap = 0, both_oe = 0, act_bad = 0;
  logic prev_clk_oe = 1'b0;
  logic [1:0] err_oe = 2'b00;
  always @(negedge CLOCK_50) begin
    cyc++;
    if (done) done_hi++;
    if (error) begin err_hi++; err_cyc = cyc; err_oe = {ps2_clk_oe, ps2_dat_oe}; end
    if (done && error) overlap++;
    if (ps2_clk_oe && ps2_dat_oe) both_oe++;
    if (active !== busy) act_bad++;
    if (ps2_clk_oe && !prev_clk_oe) inh_phases++;
    if (ps2_clk_oe) inh_run++;
    else if (prev_clk_oe) begin last_inh_len = inh_run; inh_run = 0; rts_cyc = cyc; end
    prev_clk_oe = ps2_clk_oe;
  end

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  task automatic send_cmd(input logic [7:0] b);
    @(negedge CLOCK_50);
    cmd_data = b; cmd_valid = 1'b1;
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
  endtask

  // Device: wait for RTS, clock out 10 bits sampling on rising clock, then ACK or NACK clock.
  task automatic dev_transfer(input bit nack, output logic [9:0] smp, output bit seen);
    smp = '0; seen = 1'b0;
    for (int w = 0; w < 1000; w++) begin
      @(negedge CLOCK_50);
      if (!ps2_clk_oe && ps2_dat_oe) begin seen = 1'b1; break; end
    end
    if (seen) begin
      repeat (H) @(negedge CLOCK_50);
      for (int i = 0; i < 10; i++) begin
        dev_clk = 1'b0; repeat (H) @(negedge CLOCK_50);
        smp[i] = ps2_dat_line;
        dev_clk = 1'b1; repeat (H) @(negedge CLOCK_50);
      end
      dev_dat = nack; repeat (H) @(negedge CLOCK_50);
      dev_clk = 1'b0; repeat (H) @(negedge CLOCK_50);
      dev_clk = 1'b1; repeat (H) @(negedge CLOCK_50);
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_end(input int d0, input int e0, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 9000; k++) begin
      @(negedge CLOCK_50);
      if (done_hi != d0 || err_hi != e0) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    n_chk++;
    if ({cmd_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe, active} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_state: got %b want 1000000",
               {cmd_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe, active});
    end
    reset_n = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    n_chk++;
    if ({cmd_ready, busy, ps2_clk_oe, ps2_dat_oe} !== 4'b1000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want 1000", {cmd_ready, busy, ps2_clk_oe, ps2_dat_oe});
    end
  endtask

  task automatic test_ack_byte(input logic [7:0] b);
    logic [9:0] smp, exp_f;
    bit seen, ok;
    int d0, e0;
    exp_f = frame_of(b);
    d0 = done_hi; e0 = err_hi;
    send_cmd(b);
    dev_transfer(1'b0, smp, seen);
    wait_end(d0, e0, ok);
    n_chk++;
    if (!(seen && ok)) begin n_fail++; $display("FAIL ack_%h_progress: rts=%0d end=%0d want 1 1", b, seen, ok); end
    n_chk++;
    if (last_inh_len !== INH_CYC) begin n_fail++; $display("FAIL ack_%h_inhibit_len: got %0d want %0d", b, last_inh_len, INH_CYC); end
    n_chk++;
    if (smp !== exp_f) begin n_fail++; $display("FAIL ack_%h_frame: got %b want %b", b, smp, exp_f); end
    n_chk++;
    if (smp[8] !== exp_f[8]) begin n_fail++; $display("FAIL ack_%h_parity: got %b want %b", b, smp[8], exp_f[8]); end
    n_chk++;
    if ((done_hi - d0) != 1 || (err_hi - e0) != 0) begin
      n_fail++; $display("FAIL ack_%h_pulses: done=%0d error=%0d want 1 0", b, done_hi - d0, err_hi - e0);
    end
    n_chk++;
    if ({cmd_ready, ps2_clk_oe, ps2_dat_oe} !== 3'b100) begin
      n_fail++; $display("FAIL ack_%h_idle: got %b want 100", b, {cmd_ready, ps2_clk_oe, ps2_dat_oe});
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      test_ack_byte(b);
    end
  endtask

  task automatic test_nack();
    logic [9:0] smp;
    bit seen, ok;
    int d0, e0, i0, miss;
    d0 = done_hi; e0 = err_hi; i0 = inh_phases; miss = 0;
    send_cmd(8'h00);
    for (int a = 0; a < ATTEMPTS; a++) begin
      dev_transfer(1'b1, smp, seen);
      if (!seen) miss++;
    end
    wait_end(d0, e0, ok);
    repeat (200) @(negedge CLOCK_50);
    n_chk++;
    if (miss != 0 || !ok) begin n_fail++; $display("FAIL nack_progress: missed_rts=%0d end=%0d want 0 1", miss, ok); end
    n_chk++;
    if (smp !== frame_of(8'h00)) begin n_fail++; $display("FAIL nack_frame: got %b want %b", smp, frame_of(8'h00)); end
    n_chk++;
    if ((err_hi - e0) != 1 || (done_hi - d0) != 0) begin
      n_fail++; $display("FAIL nack_pulses: error=%0d done=%0d want 1 0", err_hi - e0, done_hi - d0);
    end
    n_chk++;
    if ((inh_phases - i0) != ATTEMPTS) begin n_fail++; $display("FAIL nack_attempts: got %0d want %0d", inh_phases - i0, ATTEMPTS); end
    n_chk++;
    if (err_oe !== 2'b00 || {ps2_clk_oe, ps2_dat_oe, cmd_ready} !== 3'b001) begin
      n_fail++; $display("FAIL nack_release: at_err=%b now=%b want 00 001", err_oe, {ps2_clk_oe, ps2_dat_oe, cmd_ready});
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int d0, e0, i0;
    d0 = done_hi; e0 = err_hi; i0 = inh_phases;
    send_cmd(8'($urandom_range(0, 255)));
    wait_end(d0, e0, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL timeout_seen: got no error want error"); end
    n_chk++;
    if ((err_cyc - rts_cyc) != TO_CYC) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", err_cyc - rts_cyc, TO_CYC); end
    n_chk++;
    if (err_oe !== 2'b00) begin n_fail++; $display("FAIL timeout_release: got %b want 00", err_oe); end
    n_chk++;
    if ((err_hi - e0) != 1 || (done_hi - d0) != 0 || (inh_phases - i0) != ATTEMPTS) begin
      n_fail++; $display("FAIL timeout_pulses: error=%0d done=%0d phases=%0d want 1 0 %0d",
                         err_hi - e0, done_hi - d0, inh_phases - i0, ATTEMPTS);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int d0, e0;
    d0 = done_hi; e0 = err_hi; seen = 1'b0;
    send_cmd(8'hAA);
    for (int w = 0; w < 1000; w++) begin
      @(negedge CLOCK_50);
      if (!ps2_clk_oe && ps2_dat_oe) begin seen = 1'b1; break; end
    end
    repeat (H) @(negedge CLOCK_50);
    for (int k = 1; k <= 5; k++) begin
      dev_clk = 1'b0; repeat (H) @(negedge CLOCK_50);
      if (k < 5) begin dev_clk = 1'b1; repeat (H) @(negedge CLOCK_50); end
    end
    n_chk++;
    if (!seen || {busy, ps2_dat_oe} !== 2'b11) begin
      n_fail++; $display("FAIL midreset_bit4_drive: rts=%0d busy_dat=%b want 1 11", seen, {busy, ps2_dat_oe});
    end
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
      n_fail++; $display("FAIL midreset_async_release: got %b want 00", {ps2_clk_oe, ps2_dat_oe});
    end
    dev_clk = 1'b1;
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    n_chk++;
    if (cmd_ready !== 1'b1 || (done_hi - d0) != 0 || (err_hi - e0) != 0) begin
      n_fail++; $display("FAIL midreset_idle: ready=%b done=%0d error=%0d want 1 0 0", cmd_ready, done_hi - d0, err_hi - e0);
    end
    test_ack_byte(8'hF4);
  endtask

  task automatic test_back_to_back();
    logic [9:0] smp;
    bit seen, ok;
    int d0, e0;
    @(negedge CLOCK_50);
    cmd_data = 8'h12; cmd_valid = 1'b1;
    @(negedge CLOCK_50);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_first: busy=%b want 1", busy); end
    cmd_data = 8'h34;
    dev_transfer(1'b0, smp, seen);
    n_chk++;
    if (!seen || smp !== frame_of(8'h12)) begin n_fail++; $display("FAIL b2b_first_frame: got %b want %b", smp, frame_of(8'h12)); end
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLOCK_50);
      if (done) begin ok = 1'b1; break; end
    end
    n_chk++;
    if (!ok || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_done_cycle: done=%0d ready=%b want 1 0", ok, cmd_ready); end
    @(negedge CLOCK_50);
    n_chk++;
    if ({cmd_ready, ps2_clk_oe} !== 2'b10) begin n_fail++; $display("FAIL b2b_ready_return: got %b want 10", {cmd_ready, ps2_clk_oe}); end
    @(negedge CLOCK_50);
    n_chk++;
    if ({busy, ps2_clk_oe} !== 2'b11) begin n_fail++; $display("FAIL b2b_accept_second: got %b want 11", {busy, ps2_clk_oe}); end
    cmd_valid = 1'b0;
    d0 = done_hi; e0 = err_hi;
    dev_transfer(1'b0, smp, seen);
    wait_end(d0, e0, ok);
    n_chk++;
    if (!seen || !ok || smp !== frame_of(8'h34) || (done_hi - d0) != 1) begin
      n_fail++; $display("FAIL b2b_second_frame: got %b done=%0d want %b 1", smp, done_hi - d0, frame_of(8'h34));
    end
  endtask

  task automatic test_invariants();
    n_chk++;
    if (overlap != 0 || both_oe != 0 || act_bad != 0) begin
      n_fail++; $display("FAIL invariants: done&error=%0d both_oe=%0d active!=busy=%0d want 0 0 0", overlap, both_oe, act_bad);
    end
  endtask

  initial begin
    test_reset();
    test_ack_byte(8'hF4);
    test_ack_byte(8'hFF);
    test_random();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the mouse (e.g. 0xF4 enable reporting, 0xFF reset) over the shared PS2_CLK/PS2_DAT pins.
- Sits beside the existing PS/2 mouse receiver on the same open-collector lines. Top level muxes the tristates: a line is driven low when its oe is 1, otherwise released ('z').
- Reports device ACK/NACK and timeout so game init can bring up the mouse reliably.

Parameters:
CLK_FREQ, 50000000, system clock in Hz
INHIBIT_US, 120, host clock-inhibit time in µs (protocol min 100)
TIMEOUT_US, 15000, max time from RTS to ACK before error
SYNC_STAGES, 2, synchroniser depth on ps2_clk_in/ps2_dat_in (min 2)

Ports:
CLOCK_50  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
cmd_data  input  8  byte to send
cmd_valid  input  1  request; accepted when cmd_valid & cmd_ready
cmd_ready  output  1  high only in IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse: transfer ACKed by device
error  output  1  one-cycle pulse: NACK or timeout
ps2_clk_in  input  1  raw PS2_CLK pin value
ps2_dat_in  input  1  raw PS2_DAT pin value
ps2_clk_oe  output  1  1 = drive PS2_CLK low
ps2_dat_oe  output  1  1 = drive PS2_DAT low
active  output  1  1 while the host owns the bus; receiver ignores edges while high

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=1; busy, done, error, ps2_clk_oe, ps2_dat_oe, active = 0; counters and synchronisers cleared (synchronisers to 1).
- Inputs pass through SYNC_STAGES flops. A falling edge (fe) is sync'd clk 1 → 0, one-cycle strobe.
- INHIBIT_CYC = CLK_FREQ/1000000*INHIBIT_US (6000 at default). TIMEOUT_CYC likewise (750000 at default; timer 20 bits).
- Handshake: acceptance latches cmd_data into shift reg, computes parity = ~^cmd_data (odd), goes to INHIBIT next cycle. cmd_valid is ignored when not ready.
- INHIBIT: clk_oe=1, dat_oe=0, active=1. Lasts INHIBIT_CYC cycles, then RTS.
- RTS: dat_oe=1 (start bit 0), clk_oe=0. Timeout timer starts from 0. Bit counter = 0.
- DATA: on each fe, increment counter n:
  - n = 1..8: dat_oe = ~data[n-1] (LSB first)
  - n = 9: dat_oe = ~parity
  - n = 10: dat_oe = 0 (stop = released high)
  - n = 11: sample sync'd data; 0 → ACK state, 1 → NACK.
  - RTS and DATA are one state with counter n=0..11.
- ACK: wait until sync'd clk=1 and dat=1 (device release), then done=1 for one cycle, IDLE.
- NACK: error=1 for one cycle, release both lines, IDLE.
- Timeout: timer reaches TIMEOUT_CYC in RTS/DATA/ACK → error=1, release both lines, IDLE. Timeout wins over a same-cycle fe.
- done and error never assert together.
- ps2_clk_oe and ps2_dat_oe never both 1 except on the single INHIBIT → RTS transition cycle.
- active = busy. Outputs are registered; no combinational path from inputs to oe.
- reset_n asserted mid-transfer: both oe drop to 0 immediately (async). No done/error pulse.

Optional Feature:
- PS2_TX_RETRY_EN defined: adds parameter MAX_RETRY (default 2).
  - On NACK or timeout with retries used < MAX_RETRY, the same latched byte is resent from INHIBIT. No error pulse in that case.
  - error pulses only after the final failed attempt. done on any successful attempt.
  - Retry count resets on acceptance.
- Undefined: single attempt; behaviour as above.

Test Plan:
- Bench PS/2 device model, CLK_FREQ=1000000, INHIBIT_US=120, TIMEOUT_US=2000.
- Send 0xF4, device ACKs → clk_oe high exactly 120 cycles; device samples bits 0,0,1,0,1,1,1,1, parity 0, stop 1; done pulses once; cmd_ready back to 1.
- Send 0xFF → sampled parity = 1; done pulse; error stays 0.
- Device drives data high on the 11th clock (NACK) for 0x00 → error one cycle; both oe 0; with PS2_TX_RETRY_EN and MAX_RETRY=2, exactly 3 INHIBIT phases, then error.
- Device never clocks after RTS → error at cycle 2000 after RTS entry; oe lines released same cycle.
- reset_n low during bit 4 of 0xAA → oe=0 asynchronously; after release cmd_ready=1, no done/error; a following 0xF4 transfer succeeds.
- cmd_valid held high with 0x12 then 0x34 changed mid-transfer → only 0x12 transmitted; 0x34 accepted in the cycle after the done pulse (when cmd_ready returns to 1).
